// File: rtl/drive_cmd_pkg.sv
// Shared mode codes and ASCII command constants for the drive command decoder.
package drive_cmd_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE   = 2'd0,
    MODE_MANUAL = 2'd1,
    MODE_TRACK  = 2'd2,
    MODE_VISION = 2'd3
  } mode_t;

  localparam logic [7:0] CH_0 = 8'h30;
  localparam logic [7:0] CH_1 = 8'h31;
  localparam logic [7:0] CH_2 = 8'h32;
  localparam logic [7:0] CH_3 = 8'h33;
  localparam logic [7:0] CH_W = 8'h57;
  localparam logic [7:0] CH_A = 8'h41;
  localparam logic [7:0] CH_S = 8'h53;
  localparam logic [7:0] CH_D = 8'h44;
  localparam logic [7:0] CH_H = 8'h48;
  localparam logic [7:0] CH_N = 8'h4E;
  localparam logic [7:0] CH_L = 8'h4C;
  localparam logic [7:0] CASE_OFFSET = 8'h20;

  // Folds lowercase letters onto uppercase so command matching is case-insensitive.
  function automatic logic [7:0] to_upper(input logic [7:0] c);
    if (c >= 8'h61 && c <= 8'h7A) return c - CASE_OFFSET;
    return c;
  endfunction

endpackage

// File: rtl/duty_ramp.sv
// Free-running tick divider plus step/clamp logic that walks duty toward target.
module duty_ramp #(
  parameter int             N          = 32,
  parameter logic [N-1:0]   RAMP_STEP  = {{5{1'b0}}, 1'b1, {(N-6){1'b0}}},
  parameter int             RAMP_DIV   = 50000,
  parameter logic [N-1:0]   DUTY_RESET = {1'b1, {(N-1){1'b0}}}
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] target,
  output logic [N-1:0] duty
);

  localparam int CW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(RAMP_DIV - 1);

  logic [CW-1:0] tick_cnt;
  logic          tick;
  logic [N:0]    diff;
  logic [N-1:0]  duty_next;

  assign tick = (tick_cnt == DIV_LAST);

  // Distance is taken one bit wider than duty so the clamp test cannot wrap.
  always_comb begin
    diff      = '0;
    duty_next = duty;
    if ({1'b0, target} >= {1'b0, duty}) diff = {1'b0, target} - {1'b0, duty};
    else                                diff = {1'b0, duty} - {1'b0, target};
    if (RAMP_STEP == '0 || diff <= {1'b0, RAMP_STEP}) duty_next = target;
    else if (target > duty)                           duty_next = duty + RAMP_STEP;
    else                                              duty_next = duty - RAMP_STEP;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
      duty     <= DUTY_RESET;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      if (tick) duty <= duty_next;
    end
  end

endmodule

// File: rtl/drive_cmd_decoder.sv
// Decodes strobed UART command bytes into drive mode, steering lines and ramped PWM duty,
// with a watchdog that stops the car when manual commands go quiet.
module drive_cmd_decoder
  import drive_cmd_pkg::*;
#(
  parameter int           N              = 32,
  parameter logic [N-1:0] DUTY_HI        = 32'd1288490188,
  parameter logic [N-1:0] DUTY_MID       = 32'd2147483648,
  parameter logic [N-1:0] DUTY_LO        = 32'd2791728742,
  parameter logic [N-1:0] RAMP_STEP      = {{5{1'b0}}, 1'b1, {(N-6){1'b0}}},
  parameter int           RAMP_DIV       = 50000,
  parameter int           TIMEOUT_CYCLES = 25000000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rx_valid,
  input  logic [7:0]   rx_data,
  input  logic [2:0]   track_dir,
  input  logic [2:0]   vision_dir,
  output logic [1:0]   mode,
  output logic         left,
  output logic         straight,
  output logic         right,
  output logic [N-1:0] duty,
  output logic         cmd_err,
  output logic         timeout
);

  localparam int WCW = $clog2(TIMEOUT_CYCLES);
  localparam logic [WCW-1:0] WD_LAST = WCW'(TIMEOUT_CYCLES - 1);

  mode_t          mode_q, new_mode;
  logic [N-1:0]   target, speed_tgt;
  logic [2:0]     man_steer, man_next, steer_byte, steer_next;
  logic [WCW-1:0] wd_cnt;
  logic [7:0]     up;
  logic           is_mode, is_steer, is_speed, bad_byte, mode_change, wd_expire;

  assign mode = mode_q;

  // Steering vectors are ordered {left, straight, right}, matching track_dir/vision_dir.
  always_comb begin
    up         = to_upper(rx_data);
    is_mode    = 1'b0;
    is_steer   = 1'b0;
    is_speed   = 1'b0;
    bad_byte   = 1'b0;
    new_mode   = mode_q;
    steer_byte = 3'b000;
    speed_tgt  = target;
    if (rx_valid) begin
      case (up)
        CH_0: begin is_mode = 1'b1;  new_mode   = MODE_IDLE;   end
        CH_1: begin is_mode = 1'b1;  new_mode   = MODE_MANUAL; end
        CH_2: begin is_mode = 1'b1;  new_mode   = MODE_TRACK;  end
        CH_3: begin is_mode = 1'b1;  new_mode   = MODE_VISION; end
        CH_W: begin is_steer = 1'b1; steer_byte = 3'b010;      end
        CH_A: begin is_steer = 1'b1; steer_byte = 3'b100;      end
        CH_D: begin is_steer = 1'b1; steer_byte = 3'b001;      end
        CH_S: begin is_steer = 1'b1; steer_byte = 3'b000;      end
        CH_H: begin is_speed = 1'b1; speed_tgt  = DUTY_HI;     end
        CH_N: begin is_speed = 1'b1; speed_tgt  = DUTY_MID;    end
        CH_L: begin is_speed = 1'b1; speed_tgt  = DUTY_LO;     end
        default: bad_byte = 1'b1;
      endcase
    end

    mode_change = is_mode && (new_mode != mode_q);
    wd_expire   = (mode_q == MODE_MANUAL) && !rx_valid && (wd_cnt == WD_LAST);

    man_next = man_steer;
    if (mode_change || wd_expire)                 man_next = 3'b000;
    else if (is_steer && mode_q == MODE_MANUAL)   man_next = steer_byte;

    case (mode_q)
      MODE_IDLE:   steer_next = 3'b000;
      MODE_MANUAL: steer_next = man_next;
      MODE_TRACK:  steer_next = track_dir;
      MODE_VISION: steer_next = vision_dir;
      default:     steer_next = 3'b000;
    endcase
    if (mode_change) steer_next = 3'b000;
  end

  // A byte arriving on the expiry cycle wins: it clears the counter and keeps timeout low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q                  <= MODE_IDLE;
      target                  <= DUTY_MID;
      man_steer               <= 3'b000;
      {left, straight, right} <= 3'b000;
      cmd_err                 <= 1'b0;
      timeout                 <= 1'b0;
      wd_cnt                  <= '0;
    end else begin
      if (is_mode)  mode_q <= new_mode;
      if (is_speed) target <= speed_tgt;
      man_steer               <= man_next;
      {left, straight, right} <= steer_next;
      cmd_err                 <= bad_byte;
      if (rx_valid)       timeout <= 1'b0;
      else if (wd_expire) timeout <= 1'b1;
      if (mode_q != MODE_MANUAL || rx_valid) wd_cnt <= '0;
      else if (wd_cnt != WD_LAST)            wd_cnt <= wd_cnt + 1'b1;
    end
  end

  duty_ramp #(
    .N          (N),
    .RAMP_STEP  (RAMP_STEP),
    .RAMP_DIV   (RAMP_DIV),
    .DUTY_RESET (DUTY_MID)
  ) u_ramp (
    .clk    (clk),
    .rst_n  (rst_n),
    .target (target),
    .duty   (duty)
  );

endmodule

// File: tb/tb_drive_cmd_decoder.sv
// Directed plus randomized bench for drive_cmd_decoder against a cycle-level behavioural model.
module tb_drive_cmd_decoder;

  localparam int          N         = 32;
  localparam int          RAMP_DIV  = 4;
  localparam int          TIMEOUT   = 100;
  localparam longint      STEP      = 64'd67108864;
  localparam longint      D_HI      = 64'd1288490188;
  localparam longint      D_MID     = 64'd2147483648;
  localparam longint      D_LO      = 64'd2791728742;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         rx_valid = 1'b0;
  logic [7:0]   rx_data = 8'h00;
  logic [2:0]   track_dir = 3'b000;
  logic [2:0]   vision_dir = 3'b000;
  logic [1:0]   mode;
  logic         left, straight, right, cmd_err, timeout;
  logic [N-1:0] duty;

  int checks = 0;
  int errors = 0;

  int         m_mode;
  logic [2:0] m_lines, m_man;
  longint     m_target, m_duty, m_edges;
  bit         m_err, m_timeout;
  int         m_silence;

  drive_cmd_decoder #(
    .N              (N),
    .DUTY_HI        (32'd1288490188),
    .DUTY_MID       (32'd2147483648),
    .DUTY_LO        (32'd2791728742),
    .RAMP_STEP      (32'h0400_0000),
    .RAMP_DIV       (RAMP_DIV),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .track_dir  (track_dir),
    .vision_dir (vision_dir),
    .mode       (mode),
    .left       (left),
    .straight   (straight),
    .right      (right),
    .duty       (duty),
    .cmd_err    (cmd_err),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_mode = 0; m_lines = 3'b000; m_man = 3'b000;
    m_target = D_MID; m_duty = D_MID; m_edges = 0;
    m_err = 1'b0; m_timeout = 1'b0; m_silence = 0;
  endtask

  // One clock edge of the behavioural model, using the inputs presented during that cycle.
  task automatic modelEdge(input bit v, input logic [7:0] b);
    logic [7:0] up;
    bit         is_mode, is_steer, is_speed, changed, expire;
    int         new_mode;
    logic [2:0] sv;
    longint     gap;
    up = b;
    if (up >= 8'h61 && up <= 8'h7A) up = up - 8'h20;

    m_edges++;
    if (m_edges % RAMP_DIV == 0) begin
      gap = m_target - m_duty;
      if ((gap < 0 ? -gap : gap) <= STEP) m_duty = m_target;
      else if (gap > 0)                   m_duty = m_duty + STEP;
      else                                m_duty = m_duty - STEP;
    end

    is_mode  = v && (up inside {"0", "1", "2", "3"});
    is_steer = v && (up inside {"W", "A", "S", "D"});
    is_speed = v && (up inside {"H", "N", "L"});
    new_mode = int'(up) - 48;
    sv = (up == "W") ? 3'b010 : (up == "A") ? 3'b100 : (up == "D") ? 3'b001 : 3'b000;
    m_err   = v && !is_mode && !is_steer && !is_speed;
    changed = is_mode && (new_mode != m_mode);
    expire  = (m_mode == 1) && !v && (m_silence + 1 >= TIMEOUT);

    if (m_mode == 1 && !v) m_silence = (m_silence < TIMEOUT) ? m_silence + 1 : m_silence;
    else                   m_silence = 0;

    if (changed) begin
      m_lines = 3'b000;
      m_man   = 3'b000;
    end else begin
      case (m_mode)
        1: begin
          if (expire)        m_man = 3'b000;
          else if (is_steer) m_man = sv;
          m_lines = m_man;
        end
        2:       m_lines = track_dir;
        3:       m_lines = vision_dir;
        default: m_lines = 3'b000;
      endcase
    end

    if (v)           m_timeout = 1'b0;
    else if (expire) m_timeout = 1'b1;
    if (is_speed) m_target = (up == "H") ? D_HI : (up == "N") ? D_MID : D_LO;
    if (is_mode)  m_mode = new_mode;
  endtask

  task automatic checkModel();
    checkOutput("mode", 32'(mode), 32'(m_mode));
    checkOutput("steer", 32'({left, straight, right}), 32'(m_lines));
    checkOutput("duty", duty, m_duty[31:0]);
    checkOutput("cmd_err", 32'(cmd_err), 32'(m_err));
    checkOutput("timeout", 32'(timeout), 32'(m_timeout));
  endtask

  task automatic applyStimulus(input bit v, input logic [7:0] b);
    rx_valid = v;
    rx_data  = b;
    @(posedge clk);
    modelEdge(v, b);
    #1;
    rx_valid = 1'b0;
    checkModel();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_mode"}, 32'(mode), 32'd0);
    checkOutput({tag, "_steer"}, 32'({left, straight, right}), 32'd0);
    checkOutput({tag, "_duty"}, duty, 32'd2147483648);
    checkOutput({tag, "_cmd_err"}, 32'(cmd_err), 32'd0);
    checkOutput({tag, "_timeout"}, 32'(timeout), 32'd0);
  endtask

  initial begin
    string pool;
    int    idx;
    pool = "0123wasdWASDhnlHNLxZ?5";

    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkResetValues("reset");
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(1'b1, "1");
    applyStimulus(1'b1, "W");
    checkOutput("straight_after_W", 32'(straight), 32'd1);
    applyStimulus(1'b0, "A");
    checkOutput("unstrobed_A_left", 32'(left), 32'd0);
    applyStimulus(1'b1, "a");
    checkOutput("lower_a_left", 32'({left, straight, right}), 32'b100);
    applyStimulus(1'b1, "s");
    checkOutput("lower_s_clear", 32'({left, straight, right}), 32'b000);

    applyStimulus(1'b1, "L");
    idle(48);
    checkOutput("duty_land_lo", duty, 32'd2791728742);
    applyStimulus(1'b1, "N");
    idle(12);
    applyStimulus(1'b1, "H");
    idle(130);
    checkOutput("duty_settle_hi", duty, 32'd1288490188);

    applyStimulus(1'b1, "D");
    checkOutput("right_set", 32'(right), 32'd1);
    idle(TIMEOUT - 1);
    checkOutput("timeout_before", 32'(timeout), 32'd0);
    idle(1);
    checkOutput("timeout_fired", 32'(timeout), 32'd1);
    checkOutput("right_cleared", 32'(right), 32'd0);
    applyStimulus(1'b1, "W");
    checkOutput("timeout_cleared", 32'(timeout), 32'd0);
    checkOutput("straight_after_timeout", 32'(straight), 32'd1);

    applyStimulus(1'b1, "D");
    idle(TIMEOUT - 1);
    applyStimulus(1'b1, "A");
    checkOutput("byte_wins_timeout", 32'(timeout), 32'd0);
    checkOutput("byte_wins_left", 32'(left), 32'd1);

    track_dir = 3'b100;
    applyStimulus(1'b1, "2");
    checkOutput("track_change_clear", 32'({left, straight, right}), 32'd0);
    applyStimulus(1'b0, 8'h00);
    checkOutput("track_left", 32'(left), 32'd1);
    applyStimulus(1'b1, 8'h5A);
    checkOutput("bad_byte_err", 32'(cmd_err), 32'd1);
    applyStimulus(1'b0, 8'h00);
    checkOutput("bad_byte_err_drop", 32'(cmd_err), 32'd0);
    checkOutput("bad_byte_mode", 32'(mode), 32'd2);

    for (int i = 0; i < 1500; i++) begin
      track_dir  = 3'($urandom);
      vision_dir = 3'($urandom);
      idx = int'($urandom_range(0, pool.len() - 1));
      applyStimulus(($urandom_range(0, 5) == 0), pool[idx]);
      if ($urandom_range(0, 200) == 0) idle(int'($urandom_range(90, 110)));
    end

    #2 rst_n = 1'b0;
    #1;
    checkResetValues("async_reset");
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      track_dir  = 3'($urandom);
      vision_dir = 3'($urandom);
      idx = int'($urandom_range(0, pool.len() - 1));
      applyStimulus(($urandom_range(0, 3) == 0), pool[idx]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/drive_cmd_decoder.md
# drive_cmd_decoder

Decodes the UART command byte stream from the remote controller into drive mode, steering lines and PWM duty for the car's motor stage. It sits between the UART receiver and the PWM generator, arbitrating manual, line-tracking and vision-steering sources. Unlike the previous decoder, it qualifies every byte with a strobe and ramps duty toward a selectable target. It also stops the car when manual commands stop arriving.

## Interface
- N, 32, PWM duty width in bits
- DUTY_HI, 1288490188, duty target for 'H'
- DUTY_MID, 2147483648, duty target for 'N', also the reset target
- DUTY_LO, 2791728742, duty target for 'L'
- RAMP_STEP, 2^(N-6), duty change per ramp tick; 0 = jump to target immediately
- RAMP_DIV, 50000, clk cycles per ramp tick, ≥1
- TIMEOUT_CYCLES, 25000000, manual-mode silence before forced stop, ≥2
---
- clk  in  1  system clock; the only clock
- rst_n  in  1  reset, asynchronous, active-low
- rx_valid  in  1  one-cycle strobe: rx_data holds a new byte
- rx_data  in  8  received ASCII byte
- track_dir  in  3  line-sensor steering {left, straight, right}
- vision_dir  in  3  vision steering {left, straight, right}
- mode  out  2  0 IDLE, 1 MANUAL, 2 TRACK, 3 VISION
- left, straight, right  out  1 each  steering lines
- duty  out  N  current (ramped) PWM duty
- cmd_err  out  1  one-cycle pulse on an unrecognised byte
- timeout  out  1  high while manual watchdog has forced a stop

## Operation
- Bytes are acted on only in a cycle with rx_valid=1; rx_data is ignored otherwise.
- Letters are case-insensitive: 'w' equals 'W'.
- Mode bytes:
  - '0' → IDLE
  - '1' → MANUAL
  - '2' → TRACK
  - '3' → VISION
  - Every mode change clears left/straight/right to 0 for one cycle before a new source applies.
- MANUAL: 'W' sets straight only; 'A' sets left only; 'D' sets right only; 'S' clears all three. Lines hold until the next steering byte.
- Outside MANUAL, steering bytes are accepted without error and ignored.
- TRACK: {left,straight,right} ← track_dir every cycle.
- VISION: {left,straight,right} ← vision_dir every cycle.
- IDLE: all steering lines 0.
- Speed bytes act in every mode and set the target: 'H'→DUTY_HI, 'N'→DUTY_MID, 'L'→DUTY_LO.
- Ramp: on each tick, if |target−duty| ≤ RAMP_STEP then duty←target, else duty moves RAMP_STEP toward target. Comparison is N+1-bit unsigned, so there is no overflow or wrap.
- Watchdog:
  - The counter counts only in MANUAL.
  - It clears on any rx_valid or mode change, and saturates.
  - At TIMEOUT_CYCLES of silence, steering lines are cleared and timeout=1.
  - The next rx_valid clears timeout; that byte is then decoded normally.
- Any other byte → cmd_err pulse; no state changes.

## Timing
- Reset values: mode=0, all steering 0, duty=DUTY_MID, target=DUTY_MID, cmd_err=0, timeout=0, ramp and watchdog counters 0.
- All outputs are registered. A byte strobed in cycle k takes effect on outputs in cycle k+1, including cmd_err.
- TRACK/VISION inputs appear on the steering lines 1 cycle later.
- Ramp ticks occur every RAMP_DIV cycles, free-running from reset. A target change does not restart the tick phase.
- A target change mid-ramp redirects from the current duty; there is no overshoot.
- Timeout asserts on the cycle after the counter reaches TIMEOUT_CYCLES−1.
- If rx_valid arrives in that same cycle, the byte wins and timeout stays 0.
- rst_n assertion at any time returns every output to reset values asynchronously.

## Structure
- Package drive_cmd_pkg holds:
  - mode codes (IDLE/MANUAL/TRACK/VISION)
  - ASCII constants: '0'–'3', W A S D, H N L, plus the lowercase offset 0x20
- Sub-module duty_ramp(N, RAMP_STEP, RAMP_DIV) contains the tick counter and the step/clamp logic. Ports: clk, rst_n, target, duty.
- The top holds the byte decoder, mode register, steering mux and watchdog.

## Test plan
- Reset, then strobe '1','W'; check:
  - mode=1, straight=1 one cycle after 'W'
  - an unstrobed rx_data='A' leaves outputs unchanged
- In MANUAL, strobe 'a' then 's'; check left=1, then all steering 0 (case-insensitive).
- With RAMP_STEP=2^26 and RAMP_DIV=4, strobe 'L'; check:
  - duty rises 2^26 every 4 cycles
  - duty lands exactly on 2791728742 without overshoot
- Mid-ramp, strobe 'H'; check duty reverses and settles at 1288490188.
- With TIMEOUT_CYCLES=100, strobe '1','D' then stay silent; check:
  - right falls and timeout=1 at cycle 100
  - strobe 'W' → timeout=0, straight=1
- Strobe '2' with track_dir=3'b100, then byte 0x5A; check:
  - left=1
  - cmd_err pulses for one cycle
  - mode stays 2
